// File: rtl/ground_collider_scanner_pkg.sv
// Shared types and constants for the ground-collider scanner family.
package ground_collider_scanner_pkg;

   // Screen coordinate width and the widened width used for sum/compare.
   localparam int unsigned COORD_W     = 10;
   localparam int unsigned WIDE_W      = 11;

   // Pixels the player's feet may sit below a platform top and still stand on it.
   localparam int unsigned SNAP_MARGIN = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_EVAL = 3'd3,
      ST_DONE = 3'd4
   } scan_state_t;

endpackage : ground_collider_scanner_pkg

// File: rtl/ground_collider_scanner_overlap.sv
// Combinational test of one platform against the player box.
// Reusable by other collider scanners (ceiling, walls).
module platform_overlap_check
   import ground_collider_scanner_pkg::*;
(
   input  logic [COORD_W-1:0] px_i,
   input  logic [COORD_W-1:0] py_i,
   input  logic [COORD_W-1:0] pw_i,
   input  logic [COORD_W-1:0] ph_i,
   input  logic [COORD_W-1:0] x0_i,
   input  logic [COORD_W-1:0] x1_i,
   input  logic [COORD_W-1:0] y_i,
   input  logic               en_i,
   output logic               eligible_o
);

   logic [WIDE_W-1:0] right_c;
   logic [WIDE_W-1:0] feet_c;
   logic [WIDE_W-1:0] snap_c;

   // Horizontal strict overlap plus feet within the snap window of the top.
   always_comb begin
      right_c    = WIDE_W'(px_i) + WIDE_W'(pw_i);
      feet_c     = WIDE_W'(py_i) + WIDE_W'(ph_i);
      snap_c     = WIDE_W'(y_i) + WIDE_W'(SNAP_MARGIN);
      eligible_o = en_i
                   && (right_c > WIDE_W'(x0_i))
                   && (px_i < x1_i)
                   && (snap_c >= feet_c);
   end

endmodule : platform_overlap_check

// File: rtl/ground_collider_scanner.sv
// Per-frame platform table walk producing the player's ground collider.
// Results are published atomically on entry to DONE, so consumers never
// observe a partially scanned frame.
module ground_collider_scanner
   import ground_collider_scanner_pkg::*;
#(
   parameter int unsigned MAX_PLATFORMS = 8,
   parameter int unsigned IDX_W         = 3,
   parameter int unsigned RD_TIMEOUT    = 15
) (
   input  logic                clk_player_control,
   input  logic                reset,
   input  logic                start_scan,
   input  logic [COORD_W-1:0]  player_pos_x,
   input  logic [COORD_W-1:0]  player_pos_y,
   input  logic [COORD_W-1:0]  player_w,
   input  logic [COORD_W-1:0]  player_h,
   input  logic [3:0]          platform_count,
   output logic                plat_rd_en,
   output logic [IDX_W-1:0]    plat_rd_idx,
   input  logic                plat_rd_valid,
   input  logic [COORD_W-1:0]  plat_x0,
   input  logic [COORD_W-1:0]  plat_x1,
   input  logic [COORD_W-1:0]  plat_y,
   input  logic                plat_enable,
   output logic [COORD_W-1:0]  collider_ground_h_player,
   output logic                is_collider_ground_player,
   output logic                scan_busy,
   output logic                scan_done,
   output logic                rd_timeout
);

   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

   scan_state_t        state_q;
   logic [COORD_W-1:0] px_q, py_q, pw_q, ph_q;
   logic [COORD_W-1:0] x0_q, x1_q, y_q;
   logic               en_q;
   logic [CNT_W-1:0]   n_q;
   logic [IDX_W-1:0]   idx_q;
   logic [TMO_W-1:0]   wait_cnt_q;
   logic [COORD_W-1:0] best_q;
   logic               found_q;

   logic [COORD_W-1:0] best_d;
   logic               found_d;
   logic [CNT_W-1:0]   n_d;
   logic               last_c;
   logic               eligible_c;

   platform_overlap_check u_overlap (
      .px_i       (px_q),
      .py_i       (py_q),
      .pw_i       (pw_q),
      .ph_i       (ph_q),
      .x0_i       (x0_q),
      .x1_i       (x1_q),
      .y_i        (y_q),
      .en_i       (en_q),
      .eligible_o (eligible_c)
   );

   // Clamped entry count, running-best update and last-entry detect.
   always_comb begin
      n_d     = (32'(platform_count) > MAX_PLATFORMS) ? CNT_W'(MAX_PLATFORMS)
                                                      : CNT_W'(platform_count);
      best_d  = best_q;
      found_d = found_q;
      if (eligible_c && (!found_q || (y_q < best_q))) begin
         best_d  = y_q;
         found_d = 1'b1;
      end
      last_c  = ((CNT_W'(idx_q) + CNT_W'(1)) == n_q);
   end

   // Scan FSM with all outputs registered alongside the state transitions.
   always_ff @(posedge clk_player_control or posedge reset) begin
      if (reset) begin
         state_q                   <= ST_IDLE;
         px_q                      <= '0;
         py_q                      <= '0;
         pw_q                      <= '0;
         ph_q                      <= '0;
         x0_q                      <= '0;
         x1_q                      <= '0;
         y_q                       <= '0;
         en_q                      <= 1'b0;
         n_q                       <= '0;
         idx_q                     <= '0;
         wait_cnt_q                <= '0;
         best_q                    <= '0;
         found_q                   <= 1'b0;
         plat_rd_en                <= 1'b0;
         plat_rd_idx               <= '0;
         collider_ground_h_player  <= '0;
         is_collider_ground_player <= 1'b0;
         scan_busy                 <= 1'b0;
         scan_done                 <= 1'b0;
         rd_timeout                <= 1'b0;
      end else begin
         plat_rd_en <= 1'b0;
         scan_done  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_scan) begin
                  px_q       <= player_pos_x;
                  py_q       <= player_pos_y;
                  pw_q       <= player_w;
                  ph_q       <= player_h;
                  n_q        <= n_d;
                  idx_q      <= '0;
                  best_q     <= '0;
                  found_q    <= 1'b0;
                  rd_timeout <= 1'b0;
                  scan_busy  <= 1'b1;
                  if (n_d == '0) begin
                     state_q                   <= ST_DONE;
                     is_collider_ground_player <= 1'b0;
                     collider_ground_h_player  <= '0;
                     scan_done                 <= 1'b1;
                  end else begin
                     state_q     <= ST_REQ;
                     plat_rd_en  <= 1'b1;
                     plat_rd_idx <= '0;
                  end
               end
            end
            ST_REQ: begin
               wait_cnt_q <= '0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (plat_rd_valid) begin
                  x0_q    <= plat_x0;
                  x1_q    <= plat_x1;
                  y_q     <= plat_y;
                  en_q    <= plat_enable;
                  state_q <= ST_EVAL;
               end else if (wait_cnt_q == TMO_W'(RD_TIMEOUT - 1)) begin
                  // Unanswered entry is evaluated as a forced miss.
                  en_q       <= 1'b0;
                  rd_timeout <= 1'b1;
                  state_q    <= ST_EVAL;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TMO_W'(1);
               end
            end
            ST_EVAL: begin
               best_q  <= best_d;
               found_q <= found_d;
               if (last_c) begin
                  state_q                   <= ST_DONE;
                  is_collider_ground_player <= found_d;
                  collider_ground_h_player  <= found_d ? best_d : '0;
                  scan_done                 <= 1'b1;
               end else begin
                  idx_q       <= idx_q + IDX_W'(1);
                  plat_rd_en  <= 1'b1;
                  plat_rd_idx <= idx_q + IDX_W'(1);
                  state_q     <= ST_REQ;
               end
            end
            ST_DONE: begin
               scan_busy <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               scan_busy <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : ground_collider_scanner

// File: tb/tb_ground_collider_scanner.sv
// Directed self-checking bench for ground_collider_scanner with a
// behavioural platform-table responder and a result scoreboard.
module tb_ground_collider_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_scan;
   logic [9:0] player_pos_x, player_pos_y, player_w, player_h;
   logic [3:0] platform_count;
   logic       plat_rd_en;
   logic [2:0] plat_rd_idx;
   logic       plat_rd_valid;
   logic [9:0] plat_x0, plat_x1, plat_y;
   logic       plat_enable;
   logic [9:0] collider_ground_h_player;
   logic       is_collider_ground_player;
   logic       scan_busy, scan_done, rd_timeout;

   int checks = 0;
   int errors = 0;

   logic [9:0] t_x0 [8];
   logic [9:0] t_x1 [8];
   logic [9:0] t_y  [8];
   logic       t_en [8];
   bit         drop_en  = 1'b0;
   int         drop_idx = 0;
   int         rd_log [$];

   typedef struct {
      bit f;
      int h;
      bit tmo;
      int lat;
      int reads;
   } exp_t;
   exp_t sb [$];

   ground_collider_scanner dut (
      .clk_player_control        (clk),
      .reset                     (reset),
      .start_scan                (start_scan),
      .player_pos_x              (player_pos_x),
      .player_pos_y              (player_pos_y),
      .player_w                  (player_w),
      .player_h                  (player_h),
      .platform_count            (platform_count),
      .plat_rd_en                (plat_rd_en),
      .plat_rd_idx               (plat_rd_idx),
      .plat_rd_valid             (plat_rd_valid),
      .plat_x0                   (plat_x0),
      .plat_x1                   (plat_x1),
      .plat_y                    (plat_y),
      .plat_enable               (plat_enable),
      .collider_ground_h_player  (collider_ground_h_player),
      .is_collider_ground_player (is_collider_ground_player),
      .scan_busy                 (scan_busy),
      .scan_done                 (scan_done),
      .rd_timeout                (rd_timeout)
   );

   always #5 clk = ~clk;

   // Table responder: answers one cycle after each read request unless dropped.
   always @(posedge clk) begin
      plat_rd_valid <= 1'b0;
      if (plat_rd_en) begin
         rd_log.push_back(int'(plat_rd_idx));
         if (!(drop_en && int'(plat_rd_idx) == drop_idx)) begin
            plat_rd_valid <= 1'b1;
            plat_x0       <= t_x0[plat_rd_idx];
            plat_x1       <= t_x1[plat_rd_idx];
            plat_y        <= t_y[plat_rd_idx];
            plat_enable   <= t_en[plat_rd_idx];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_ent(input int i, input int x0, input int x1, input int y, input bit en);
      t_x0[i] = 10'(x0);
      t_x1[i] = 10'(x1);
      t_y[i]  = 10'(y);
      t_en[i] = en;
   endtask

   // Reference: nearest eligible top over the first n entries, integer math.
   task automatic model(input int n, output bit f, output int h);
      int px, py, pw, ph;
      px = int'(player_pos_x); py = int'(player_pos_y);
      pw = int'(player_w);     ph = int'(player_h);
      f = 1'b0;
      h = 0;
      for (int i = 0; i < n; i++) begin
         if (drop_en && i == drop_idx) continue;
         if (t_en[i] && (px + pw > int'(t_x0[i])) && (px < int'(t_x1[i]))
             && (int'(t_y[i]) + 2 >= py + ph)) begin
            if (!f || int'(t_y[i]) < h) begin
               h = int'(t_y[i]);
               f = 1'b1;
            end
         end
      end
   endtask

   task automatic do_scan(input int cnt, input int spur);
      exp_t e;
      int   n;
      int   lat;
      n = (cnt > 8) ? 8 : cnt;
      model(n, e.f, e.h);
      e.tmo   = drop_en && (drop_idx < n);
      e.lat   = 3 * n + 1;
      e.reads = n;
      sb.push_back(e);
      rd_log.delete();
      @(negedge clk);
      platform_count = 4'(cnt);
      start_scan     = 1'b1;
      @(negedge clk);
      start_scan = 1'b0;
      lat = 1;
      check("busy_after_start", 32'(scan_busy), 32'd1);
      check("tmo_cleared", 32'(rd_timeout), 32'd0);
      while (!scan_done && lat < 400) begin
         start_scan = (lat == spur);
         @(negedge clk);
         lat++;
      end
      start_scan = 1'b0;
      e = sb.pop_front();
      check("done_seen", 32'(scan_done), 32'd1);
      check("found", 32'(is_collider_ground_player), 32'(e.f));
      check("height", 32'(collider_ground_h_player), 32'(e.h));
      check("rd_timeout", 32'(rd_timeout), 32'(e.tmo));
      if (!e.tmo) check("latency", 32'(lat), 32'(e.lat));
      check("reads", 32'(rd_log.size()), 32'(e.reads));
      if (n > 0 && rd_log.size() > 0) begin
         check("first_idx", 32'(rd_log[0]), 32'd0);
         check("last_idx", 32'(rd_log[$]), 32'(n - 1));
      end
      @(negedge clk);
      check("done_pulse", 32'(scan_done), 32'd0);
      check("idle_busy", 32'(scan_busy), 32'd0);
      check("hold_h", 32'(collider_ground_h_player), 32'(e.h));
   endtask

   initial begin
      bit   saw_done;
      int   guard;
      reset          = 1'b1;
      start_scan     = 1'b0;
      player_pos_x   = 10'd320;
      player_pos_y   = 10'd240;
      player_w       = 10'd30;
      player_h       = 10'd30;
      platform_count = 4'd0;
      plat_rd_valid  = 1'b0;
      plat_x0        = '0;
      plat_x1        = '0;
      plat_y         = '0;
      plat_enable    = 1'b0;
      for (int i = 0; i < 8; i++) set_ent(i, 0, 0, 0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_h", 32'(collider_ground_h_player), 32'd0);
      check("rst_found", 32'(is_collider_ground_player), 32'd0);
      check("rst_busy", 32'(scan_busy), 32'd0);
      check("rst_done", 32'(scan_done), 32'd0);
      check("rst_tmo", 32'(rd_timeout), 32'd0);
      check("rst_rd_en", 32'(plat_rd_en), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single platform under the player
      set_ent(0, 300, 360, 300, 1'b1);
      do_scan(1, 0);

      // Nearest of two, both orders, then a tie
      set_ent(0, 300, 360, 300, 1'b1);
      set_ent(1, 300, 360, 280, 1'b1);
      do_scan(2, 0);
      set_ent(0, 300, 360, 280, 1'b1);
      set_ent(1, 300, 360, 300, 1'b1);
      do_scan(2, 0);
      set_ent(0, 300, 360, 280, 1'b1);
      set_ent(1, 300, 360, 280, 1'b1);
      do_scan(2, 0);

      // Boundaries
      set_ent(0, 300, 360, 267, 1'b1);
      do_scan(1, 0);
      set_ent(0, 350, 400, 300, 1'b1);
      do_scan(1, 0);
      set_ent(0, 250, 320, 300, 1'b1);
      do_scan(1, 0);
      set_ent(0, 300, 360, 300, 1'b0);
      do_scan(1, 0);
      set_ent(0, 300, 360, 268, 1'b1);
      do_scan(1, 0);

      // Empty table clears outputs; oversized count is clamped to 8
      do_scan(0, 0);
      for (int i = 0; i < 8; i++) set_ent(i, 300, 360, 300 - i * 4, 1'b1);
      set_ent(3, 300, 360, 200, 1'b1);
      set_ent(7, 300, 360, 269, 1'b1);
      do_scan(12, 0);

      // Unanswered read on index 1 of 3
      set_ent(0, 300, 360, 300, 1'b1);
      set_ent(1, 300, 360, 270, 1'b1);
      set_ent(2, 300, 360, 290, 1'b1);
      drop_en  = 1'b1;
      drop_idx = 1;
      do_scan(3, 0);
      drop_en = 1'b0;
      do_scan(3, 0);

      // start_scan during a scan is ignored
      do_scan(3, 3);

      // Reset while waiting on index 2 aborts the scan
      drop_en  = 1'b1;
      drop_idx = 2;
      rd_log.delete();
      @(negedge clk);
      platform_count = 4'd3;
      start_scan     = 1'b1;
      @(negedge clk);
      start_scan = 1'b0;
      guard = 0;
      while (rd_log.size() < 3 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("reached_idx2", 32'(rd_log.size()), 32'd3);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_h", 32'(collider_ground_h_player), 32'd0);
      check("abort_found", 32'(is_collider_ground_player), 32'd0);
      check("abort_busy", 32'(scan_busy), 32'd0);
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (scan_done) saw_done = 1'b1;
      end
      reset   = 1'b0;
      drop_en = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (scan_done) saw_done = 1'b1;
      end
      check("no_done_after_abort", 32'(saw_done), 32'd0);
      do_scan(3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_ground_collider_scanner
